// File: rtl/adder_flit_injector.sv
// adder_flit_injector: packet-based walking-thermometer stimulus generator for the adder.
// Pattern is (fill, k): top k*STEP_BITS bits set (fill) or cleared (drain).
module adder_flit_injector #(
    parameter int N         = 26,
    parameter int STEP_BITS = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic [CNT_W-1:0] num_packets,
    input  logic [CNT_W-1:0] payload_len,
    input  logic [CNT_W-1:0] gap_len,
    output logic [N-1:0]     operand_a,
    output logic [N-1:0]     operand_b,
    output logic             flit_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] flit_cnt
);
    localparam int W  = 2 * N;
    localparam int G  = W / STEP_BITS;
    localparam int KW = $clog2(G + 1);
    localparam int SW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] np_q, pl_q, gl_q, np_n, pl_n, gl_n;
    logic [CNT_W-1:0] gap_cnt, gap_n, pkt_n, flit_n, pkt_inc;
    logic             fill, fill_n, fv, fv_n, adv, restart, bf, wrap;
    logic [KW-1:0]    k, k_n, bk;
    logic [SW-1:0]    sh;
    logic [W-1:0]     low, pattern;

    assign sh         = SW'(k) * SW'(STEP_BITS);
    assign low        = {W{1'b1}} >> sh;
    assign pattern    = fill ? ~low : low;
    assign operand_a  = pattern[N-1:0];
    assign operand_b  = pattern[W-1:N];
    assign flit_valid = fv & ~pause;
    assign busy       = (state == SEND) || (state == GAP);
    assign done       = state == DONE;
    assign pkt_inc    = pkt_cnt + CNT_W'(1);

    always_comb begin
        state_n = state;
        np_n    = np_q;
        pl_n    = pl_q;
        gl_n    = gl_q;
        gap_n   = gap_cnt;
        pkt_n   = pkt_cnt;
        flit_n  = flit_cnt;
        fv_n    = fv;
        adv     = 1'b0;
        restart = 1'b0;
        case (state)
            IDLE: if (start) begin
                np_n    = num_packets;
                pl_n    = payload_len;
                gl_n    = gap_len;
                pkt_n   = '0;
                flit_n  = '0;
                state_n = DONE;
                if (num_packets != '0 && payload_len != '0) begin
                    state_n = SEND;
                    restart = 1'b1;
                    adv     = 1'b1;
                    fv_n    = 1'b1;
                    flit_n  = CNT_W'(1);
                end
            end
            SEND: if (flit_cnt != pl_q) begin
                adv    = 1'b1;
                flit_n = flit_cnt + CNT_W'(1);
            end else begin
                pkt_n = pkt_inc;
                if (gl_q != '0) begin
                    state_n = GAP;
                    fv_n    = 1'b0;
                    gap_n   = CNT_W'(1);
                end else if (pkt_inc == np_q) begin
                    state_n = DONE;
                    fv_n    = 1'b0;
                end else begin
                    restart = 1'b1;
                    adv     = 1'b1;
                    flit_n  = CNT_W'(1);
                end
            end
            GAP: if (gap_cnt != gl_q) begin
                gap_n = gap_cnt + CNT_W'(1);
            end else if (pkt_cnt == np_q) begin
                state_n = DONE;
            end else begin
                state_n = SEND;
                restart = 1'b1;
                adv     = 1'b1;
                fv_n    = 1'b1;
                flit_n  = CNT_W'(1);
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // a new packet steps from the cleared pattern (fill, k=0)
        bf     = restart | fill;
        bk     = restart ? '0 : k;
        wrap   = bk == KW'(G);
        fill_n = adv ? (wrap ? ~bf : bf) : fill;
        k_n    = adv ? (wrap ? KW'(1) : bk + KW'(1)) : k;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            np_q     <= '0;
            pl_q     <= '0;
            gl_q     <= '0;
            gap_cnt  <= '0;
            pkt_cnt  <= '0;
            flit_cnt <= '0;
            fv       <= 1'b0;
            fill     <= 1'b1;
            k        <= '0;
        end else if (!pause) begin
            state    <= state_n;
            np_q     <= np_n;
            pl_q     <= pl_n;
            gl_q     <= gl_n;
            gap_cnt  <= gap_n;
            pkt_cnt  <= pkt_n;
            flit_cnt <= flit_n;
            fv       <= fv_n;
            fill     <= fill_n;
            k        <= k_n;
        end
    end
endmodule

// File: tb/tb_adder_flit_injector.sv
// tb_adder_flit_injector: random runs checked every cycle against an expected-trace model.
module tb_adder_flit_injector;
    localparam int N  = 26;
    localparam int W  = 2 * N;
    localparam int CW = 16;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0;
    logic [CW-1:0] num_packets = '0, payload_len = '0, gap_len = '0;
    logic [N-1:0]  operand_a, operand_b;
    logic          flit_valid, busy, done;
    logic [CW-1:0] pkt_cnt, flit_cnt;

    adder_flit_injector #(.N(N), .STEP_BITS(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .num_packets(num_packets), .payload_len(payload_len), .gap_len(gap_len),
        .operand_a(operand_a), .operand_b(operand_b), .flit_valid(flit_valid),
        .busy(busy), .done(done), .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [N-1:0]  a, b;
        logic [CW-1:0] fc, pc;
        logic          busy, done;
    } ent_t;

    ent_t q[$];
    ent_t idle;
    bit   chk_en = 1'b0;
    int   total = 0, bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // flit f of a packet: position in the 2W/STEP walk, then fill or drain mask
    function automatic logic [W-1:0] pat(int f);
        int pos = (f - 1) % W;
        int kk  = (pos < N) ? pos + 1 : pos - N + 1;
        logic [63:0] lowm = (64'd1 << (W - 2 * kk)) - 64'd1;
        return (pos < N) ? ~lowm[W-1:0] : lowm[W-1:0];
    endfunction

    function automatic ent_t mk(logic v, logic [W-1:0] p, int fc, int pc, logic b, logic d);
        ent_t e;
        e.v = v; e.a = p[N-1:0]; e.b = p[W-1:N];
        e.fc = CW'(fc); e.pc = CW'(pc); e.busy = b; e.done = d;
        return e;
    endfunction

    task automatic gen_run(int n, int p, int g);
        if (n == 0 || p == 0) begin
            q.push_back(mk(1'b0, {idle.b, idle.a}, 0, 0, 1'b0, 1'b1));
            return;
        end
        for (int pk = 1; pk <= n; pk++) begin
            for (int f = 1; f <= p; f++) q.push_back(mk(1'b1, pat(f), f, pk - 1, 1'b1, 1'b0));
            for (int i = 0; i < g; i++) q.push_back(mk(1'b0, pat(p), p, pk, 1'b1, 1'b0));
            if (pk == n) q.push_back(mk(1'b0, pat(p), p, n, 1'b0, 1'b1));
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        ent_t e;
        e = (q.size() > 0) ? q[0] : idle;
        chk("flit_valid", flit_valid, e.v & ~pause);
        chk("operand_a", operand_a, e.a);
        chk("operand_b", operand_b, e.b);
        chk("flit_cnt", flit_cnt, e.fc);
        chk("pkt_cnt", pkt_cnt, e.pc);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
    end

    always @(posedge clk) if (chk_en && !pause && q.size() > 0) begin
        idle = q.pop_front();
        idle.v = 1'b0; idle.busy = 1'b0; idle.done = 1'b0;
    end

    task automatic start_run(int n, int p, int g);
        @(posedge clk); #1;
        num_packets = CW'(n); payload_len = CW'(p); gap_len = CW'(g);
        start = 1'b1; pause = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        gen_run(n, p, g);
    endtask

    task automatic drain(int pp, int sp, output int dc, output int vc);
        dc = -1; vc = 0;
        for (int i = 0; i < 5000 && q.size() > 0; i++) begin
            @(negedge clk);
            if (flit_valid) vc++;
            if (done && dc < 0) dc = i;
            @(posedge clk); #1;
            pause = (q.size() > 0) && ($urandom_range(99) < pp);
            if (q.size() > 0 && $urandom_range(99) < sp) begin
                start = 1'b1;
                num_packets = CW'($urandom); payload_len = CW'($urandom); gap_len = CW'($urandom);
            end else start = 1'b0;
        end
        if (q.size() > 0) begin
            chk("timeout", q.size(), 0);
            q.delete();
        end
        pause = 1'b0; start = 1'b0;
    endtask

    initial begin
        int dc, vc;
        logic [W-1:0] p;
        #12;
        chk("rst_valid", flit_valid, 0);
        chk("rst_a", operand_a, 0);
        chk("rst_b", operand_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_flit", flit_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        idle = mk(1'b0, '0, 0, 0, 1'b0, 1'b0);
        chk_en = 1'b1;

        p = pat(1);  chk("pin_f1", p, {26'h3000000, 26'h0});
        p = pat(2);  chk("pin_f2", p, {26'h3C00000, 26'h0});
        p = pat(3);  chk("pin_f3", p, {26'h3F00000, 26'h0});
        p = pat(13); chk("pin_f13", p, {26'h3FFFFFF, 26'h0});
        p = pat(20); chk("pin_f20", p, {26'h3FFFFFF, 26'h3FFF000});
        p = pat(26); chk("pin_f26", p, {26'h3FFFFFF, 26'h3FFFFFF});
        p = pat(27); chk("pin_f27", p, {26'h0FFFFFF, 26'h3FFFFFF});
        p = pat(52); chk("pin_f52", p, {26'h0, 26'h0});
        p = pat(53); chk("pin_f53", p, {26'h3000000, 26'h0});

        start_run(1, 3, 7);  drain(0, 0, dc, vc);
        chk("run1_done_cyc", dc, 10);
        chk("run1_flits", vc, 3);
        start_run(1, 20, 0); drain(0, 0, dc, vc);
        start_run(1, 60, 0); drain(0, 0, dc, vc);
        chk("run60_flits", vc, 60);
        start_run(10, 20, 7); drain(0, 30, dc, vc);
        chk("run10_flits", vc, 200);
        chk("run10_done_cyc", dc, 270);
        start_run(3, 5, 0);  drain(0, 0, dc, vc);
        chk("b2b_done_cyc", dc, 15);
        start_run(0, 5, 3);  drain(0, 0, dc, vc);
        chk("np0_done_cyc", dc, 0);
        chk("np0_flits", vc, 0);
        start_run(3, 0, 2);  drain(0, 0, dc, vc);
        chk("pl0_flits", vc, 0);

        start_run(2, 10, 3);
        repeat (4) @(posedge clk);
        #1 pause = 1'b1;
        #1 chk("pause_fv", flit_valid, 0);
        repeat (5) @(posedge clk);
        #1 pause = 1'b0;
        drain(0, 0, dc, vc);

        for (int r = 0; r < 14; r++) begin
            start_run($urandom_range(4), $urandom_range(30), $urandom_range(4));
            drain(20, 20, dc, vc);
        end

        start_run(1, 3, 7);
        repeat (5) @(posedge clk);
        #1 chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", flit_valid, 0);
        chk("arst_a", operand_a, 0);
        chk("arst_b", operand_b, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pkt", pkt_cnt, 0);
        chk("arst_flit", flit_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        idle = mk(1'b0, '0, 0, 0, 1'b0, 1'b0);
        chk_en = 1'b1;
        start_run(2, 4, 1); drain(0, 0, dc, vc);
        chk("post_rst_flits", vc, 8);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
